// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register with load/shift/rotate/clear modes
// and a burst engine that repeats a shift/rotate op a programmed number of times.
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter int               AMT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [AMT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic             r_busy;
  logic             r_done;

  logic             w_burst_req;
  logic             w_last_step;
  logic [WIDTH-1:0] w_single_q;
  logic [WIDTH-1:0] w_step_q;

  function automatic logic [WIDTH-1:0] f_apply(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] din,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] res;
    res = cur;
    case (op)
      M_HOLD:  res = cur;
      M_LOAD:  res = din;
      M_SHL:   res = {cur[WIDTH-2:0], sr};
      M_SHR:   res = {sl, cur[WIDTH-1:1]};
      M_ROL:   res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ROR:   res = {cur[0], cur[WIDTH-1:1]};
      M_ASR:   res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      M_CLR:   res = '0;
      default: res = cur;
    endcase
    return res;
  endfunction

  // Only the shift/rotate family can be repeated as a burst
  assign w_burst_req = start && (mode >= M_SHL) && (mode <= M_ASR);
  assign w_last_step = (r_cnt == AMT_W'(1));
  assign w_single_q  = f_apply(mode, r_q, d, sin_l, sin_r);
  assign w_step_q    = f_apply(r_op, r_q, d, sin_l, sin_r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_q     <= RESET_VAL;
      r_cnt   <= '0;
      r_op    <= M_HOLD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_burst_req) begin
            r_op <= mode;
            if (amt == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= RUN;
              r_cnt   <= amt;
              r_busy  <= 1'b1;
            end
          end else if (en) begin
            r_q <= w_single_q;
          end
        end
        RUN: begin
          if (en) begin
            r_q   <= w_step_q;
            r_cnt <= r_cnt - AMT_W'(1);
            if (w_last_step) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign q      = r_q;
  assign qbar   = ~r_q;
  assign sout_l = r_q[WIDTH-1];
  assign sout_r = r_q[0];
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios plus random traffic
// against an arithmetic reference model.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin_l;
  logic       sin_r;
  logic       start;
  logic [3:0] amt;
  logic [7:0] q;
  logic [7:0] qbar;
  logic       sout_l;
  logic       sout_r;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  int m_q;
  int m_busy;
  int m_rem;
  int m_op;
  int m_done;
  int busy_seen;

  univ_shift_reg #(.WIDTH(8), .AMT_W(4), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .start(start), .amt(amt),
    .q(q), .qbar(qbar), .sout_l(sout_l), .sout_r(sout_r),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Register value after one op, in plain 8-bit arithmetic
  function automatic int ref_op(int op, int cur, int din, int sl, int sr);
    case (op)
      0: return cur;
      1: return din;
      2: return (cur * 2 + sr) % 256;
      3: return cur / 2 + sl * 128;
      4: return (cur * 2) % 256 + cur / 128;
      5: return cur / 2 + (cur % 2) * 128;
      6: return cur / 2 + (cur / 128) * 128;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_q    = 0;
    m_busy = 0;
    m_rem  = 0;
    m_op   = 0;
    m_done = 0;
  endtask

  task automatic chk_all();
    chk("q", 32'(q), m_q);
    chk("qbar", 32'(qbar), (~m_q) & 255);
    chk("sout_l", 32'(sout_l), m_q / 128);
    chk("sout_r", 32'(sout_r), m_q % 2);
    chk("busy", 32'(busy), m_busy);
    chk("done", 32'(done), m_done);
  endtask

  // One clock: predict from pre-edge inputs, then check 1ns after the edge
  task automatic cyc();
    int nq, ndone;
    nq    = m_q;
    ndone = 0;
    if (m_busy == 0) begin
      if (start && mode >= 2 && mode <= 6) begin
        m_op = int'(mode);
        if (amt == 0) ndone = 1;
        else begin
          m_busy = 1;
          m_rem  = int'(amt);
        end
      end else if (en) begin
        nq = ref_op(int'(mode), m_q, int'(d), int'(sin_l), int'(sin_r));
      end
    end else if (en) begin
      nq = ref_op(m_op, m_q, int'(d), int'(sin_l), int'(sin_r));
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 0;
        ndone  = 1;
      end
    end
    @(posedge clk);
    #1;
    m_q    = nq;
    m_done = ndone;
    busy_seen += int'(busy);
    chk_all();
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_q", 32'(q), 0);
    chk("rst_qbar", 32'(qbar), 32'hff);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    #2;
    rst = 1'b0;
  endtask

  task automatic drive(input logic [2:0] m, input logic e, input logic s,
                       input logic [3:0] a, input logic [7:0] dv);
    mode  = m;
    en    = e;
    start = s;
    amt   = a;
    d     = dv;
  endtask

  initial begin
    rst = 1'b1;
    drive(3'b000, 1'b0, 1'b0, 4'd0, 8'h00);
    sin_l = 1'b0;
    sin_r = 1'b0;
    model_reset();
    busy_seen = 0;
    #12;
    rst = 1'b0;
    #1;
    chk_all();

    drive(3'b001, 1'b1, 1'b0, 4'd0, 8'hff); cyc();
    do_reset();

    drive(3'b001, 1'b1, 1'b0, 4'd0, 8'ha5); cyc();
    drive(3'b100, 1'b1, 1'b0, 4'd0, 8'h00); cyc();
    chk("rol", 32'(q), 32'h4b);
    drive(3'b001, 1'b1, 1'b0, 4'd0, 8'h96); cyc();
    drive(3'b110, 1'b1, 1'b0, 4'd0, 8'h00); cyc();
    chk("asr", 32'(q), 32'hcb);
    drive(3'b001, 1'b1, 1'b0, 4'd0, 8'h0f); cyc();
    sin_r = 1'b1;
    drive(3'b010, 1'b1, 1'b0, 4'd0, 8'h00); cyc();
    chk("shl", 32'(q), 32'h1f);
    chk("shl_soutr", 32'(sout_r), 1);
    sin_r = 1'b0;

    drive(3'b001, 1'b1, 1'b0, 4'd0, 8'h81); cyc();
    busy_seen = 0;
    drive(3'b101, 1'b1, 1'b1, 4'd3, 8'h00); cyc();
    chk("bst_hold", 32'(q), 32'h81);
    drive(3'b000, 1'b1, 1'b0, 4'd0, 8'h00);
    cyc(); chk("bst1", 32'(q), 32'hc0);
    cyc(); chk("bst2", 32'(q), 32'h60);
    cyc(); chk("bst3", 32'(q), 32'h30);
    chk("bst_done", 32'(done), 1);
    cyc(); chk("bst_done_off", 32'(done), 0);
    chk("bst_busy_len", busy_seen, 3);

    drive(3'b001, 1'b1, 1'b0, 4'd0, 8'h81); cyc();
    busy_seen = 0;
    drive(3'b101, 1'b1, 1'b1, 4'd3, 8'h00); cyc();
    drive(3'b000, 1'b1, 1'b0, 4'd0, 8'h00); cyc();
    drive(3'b010, 1'b0, 1'b1, 4'd7, 8'hee); cyc(); cyc();
    chk("stall_hold", 32'(q), 32'hc0);
    drive(3'b000, 1'b1, 1'b0, 4'd0, 8'h00); cyc(); cyc();
    chk("stall_q", 32'(q), 32'h30);
    chk("stall_done", 32'(done), 1);
    chk("stall_busy_len", busy_seen, 5);

    busy_seen = 0;
    drive(3'b010, 1'b1, 1'b1, 4'd0, 8'h00); cyc();
    chk("zero_done", 32'(done), 1);
    chk("zero_q", 32'(q), 32'h30);
    drive(3'b010, 1'b1, 1'b1, 4'd2, 8'h00); cyc();
    drive(3'b000, 1'b1, 1'b0, 4'd0, 8'h00); cyc(); cyc();
    chk("b2b_q", 32'(q), 32'hc0);
    chk("b2b_busy_len", busy_seen, 2);

    drive(3'b011, 1'b1, 1'b1, 4'd4, 8'h00); cyc();
    drive(3'b000, 1'b1, 1'b0, 4'd0, 8'h00); cyc(); cyc();
    do_reset();
    cyc(); cyc();
    drive(3'b001, 1'b1, 1'b0, 4'd0, 8'h5a); cyc();
    chk("post_rst_load", 32'(q), 32'h5a);

    for (int i = 0; i < 3000; i++) begin
      mode  = 3'($urandom_range(0, 7));
      en    = ($urandom_range(0, 9) < 8);
      start = ($urandom_range(0, 9) < 3);
      amt   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      d     = 8'($urandom);
      sin_l = 1'($urandom);
      sin_r = 1'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset();
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register with enable, parallel load, clear, logical/arithmetic shift and rotate modes. It also has a burst engine that performs a programmed number of shift/rotate steps with busy/done handshaking. It serves as the general-purpose storage/serialiser element for datapath and serial-link blocks. It provides true and complemented outputs like the basic flop.

Parameters:
WIDTH, 8, register width in bits (>=2)
AMT_W, 4, width of burst shift-amount port; amt values up to 2^AMT_W-1 are legal (values > WIDTH are allowed and simply keep shifting)
RESET_VAL, 0, value loaded into q on reset (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
en  input  1  clock enable; gates single-step operations and burst steps
mode  input  3  operation select (encoding below)
d  input  WIDTH  parallel load data
sin_l  input  1  serial in at MSB (used by shift right)
sin_r  input  1  serial in at LSB (used by shift left)
start  input  1  request burst of amt steps using mode
amt  input  AMT_W  burst step count
q  output  WIDTH  register contents
qbar  output  WIDTH  ~q, combinational
sout_l  output  1  q[WIDTH-1], combinational
sout_r  output  1  q[0], combinational
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high. While rst=1: q=RESET_VAL, busy=0, done=0, FSM=IDLE, step counter=0. Reset mid-burst aborts the burst with no done pulse.
- Mode encoding:
  - 000 hold
  - 001 load d
  - 010 shift left: {q[W-2:0],sin_r}
  - 011 shift right: {sin_l,q[W-1:1]}
  - 100 rotate left
  - 101 rotate right
  - 110 arithmetic shift right: {q[W-1],q[W-1:1]}
  - 111 clear to 0
- Single-step operation: in IDLE with start=0 and en=1, the mode op is applied at the rising edge (1-cycle latency). With en=0, q holds.
- FSM has two states, IDLE and RUN.
- IDLE, start=1, mode in {010..110}:
  - Latch mode and amt; q is unchanged this cycle regardless of en.
  - amt=0: stay IDLE, done=1 next cycle, busy stays 0.
  - amt>0: go to RUN, cnt=amt, busy=1 from next cycle.
- IDLE, start=1, mode in {000,001,111}: treated as a single-step op gated by en. No burst, no done.
- RUN:
  - Each cycle with en=1: apply the latched op once, cnt decrements.
  - Each cycle with en=0: stall; q and cnt hold, busy stays 1.
  - When the step taken with cnt=1 completes: go to IDLE, busy=0, done=1 for exactly one cycle. q shows the final value in that same cycle.
- While busy: mode, d, amt and start are ignored. A start in the done cycle is accepted as a new burst (back-to-back bursts allowed).
- sin_l/sin_r are sampled live at every burst step, not latched at start.
- done is registered and never asserted outside the single completion cycle.

Test Plan:
(All scenarios use WIDTH=8, AMT_W=4, RESET_VAL=0.)
- Reset: assert rst asynchronously between clock edges -> q=0x00, qbar=0xFF, busy=0 and done=0 immediately, without waiting for clk.
- Single ops: load 0xA5 (en=1), then rotate left -> q=0x4B. Then mode=110 on a loaded 0x96 -> q=0xCB. Then shift left with sin_r=1 on 0x0F -> 0x1F, sout_l/sout_r track q.
- Burst: load 0x81, start with mode=101, amt=3, en=1 -> busy high 3 cycles, q goes 0xC0, 0x60, 0x30, done pulses once with q=0x30.
- Stall: same burst with en=0 for 2 cycles mid-burst -> busy lasts 5 cycles, final q=0x30, single done pulse. A start asserted during busy with a different mode is ignored.
- Zero and back-to-back: start with amt=0 -> done pulses next cycle, busy never high, q unchanged. start again in the done cycle with mode=010, amt=2, sin_r=0 -> q shifted left by 2.
- Reset mid-burst: rst during RUN with cnt=2 -> q=0x00, busy=0, no done pulse. After release, single-step load works on the next edge.
